// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] CNT_LOAD   = 5'(ITER_COUNT - 1);

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration over a 64-bit working register.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next,
    output logic        qbit
);

    logic [32:0] sum;
    logic [31:0] diff;
    logic        fits;

    // Divide: acc[63:31] is the 33-bit partial remainder with the next dividend bit
    // shifted in; the freed low bit is left at zero for the caller to fill with qbit.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
        fits     = (acc[63:31] >= {1'b0, operand});
        diff     = acc[62:31] - operand;
        qbit     = 1'b0;
        acc_next = {sum, acc[31:1]};
        if (is_div) begin
            qbit     = fits;
            acc_next = {(fits ? diff : acc[62:31]), acc[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] operand;
    logic [31:0] rs_raw;
    logic        is_div;
    logic        div0;
    logic        neg_q;
    logic        neg_r;
    logic        step_qbit;
    logic        op_signed;
    logic        op_div;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // start/mf_req/mthi/mtlo are offered by the pipeline and taken only while idle;
    // stall tells it to hold and re-present any request raised while busy.
    assign busy      = (state != IDLE);
    assign stall     = busy & (start | mf_req | mthi | mtlo);
    assign dbg_state = state;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign rs_mag    = op_signed ? abs32(rs_val) : rs_val;
    assign rt_mag    = op_signed ? abs32(rt_val) : rt_val;

    assign prod_fix = neg_q ? (64'd0 - acc) : acc;
    assign quo_fix  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

    muldiv_step u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next),
        .qbit     (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            rs_raw  <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        cnt    <= CNT_LOAD;
                        is_div <= op_div;
                        rs_raw <= rs_val;
                        div0   <= (rt_val == '0);
                        neg_q  <= op_signed & (rs_val[31] ^ rt_val[31]);
                        neg_r  <= op_signed & rs_val[31];
                        if (op_div) begin
                            acc     <= {32'd0, rs_mag};
                            operand <= rt_mag;
                        end else begin
                            acc     <= {32'd0, rt_mag};
                            operand <= rs_mag;
                        end
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                RUN: begin
                    acc <= {acc_next[63:1], acc_next[0] | step_qbit};
                    if (cnt == 5'd0) state <= FIX;
                    else             cnt   <= cnt - 5'd1;
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (div0) begin
                        hi <= rs_raw;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
